// File: rtl/equiv_sweeper.sv
// Sequential truth-table equivalence sweeper: walks all 2^N input combinations, counting mismatches.
// Optional early termination on the first mismatch is compiled in with EQUIV_SWEEPER_EARLY_STOP_EN.
`timescale 1ns/1ps
module equiv_sweeper #(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [(1<<N)-1:0]   spec_tt,
    input  logic [(1<<N)-1:0]   impl_tt,
    output logic                busy,
    output logic                done,
    output logic                equal,
    output logic [N-1:0]        vec,
    output logic [N:0]          mis_cnt,
    output logic [N-1:0]        first_mis,
    output logic                first_valid
);

    localparam int             TT_W    = 1 << N;
    localparam logic [N-1:0]   VEC_ONE = N'(1);
    localparam logic [N-1:0]   VEC_MAX = {N{1'b1}};
    localparam logic [N:0]     CNT_ONE = (N+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [TT_W-1:0]    r_spec;
    logic [TT_W-1:0]    r_impl;
    logic [N-1:0]       r_vec;
    logic [N:0]         r_mis_cnt;
    logic [N-1:0]       r_first_mis;
    logic               r_first_valid;

    logic [TT_W-1:0]    w_diff_vec;
    logic               w_diff;
    logic               w_last;
    logic               w_stop;
    logic               w_launch;

    genvar gi;
    generate
        for (gi = 0; gi < TT_W; gi++) begin : g_diff
            assign w_diff_vec[gi] = r_spec[gi] ^ r_impl[gi];
        end
    endgenerate

    assign w_diff   = w_diff_vec[r_vec];
    assign w_last   = (r_vec == VEC_MAX);
    assign w_launch = start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef EQUIV_SWEEPER_EARLY_STOP_EN
    assign w_stop = w_last || w_diff;
`else
    assign w_stop = w_last;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_SWEEP;
            S_SWEEP: if (w_stop) w_state_next = S_DONE;
            S_DONE:  if (start)  w_state_next = S_SWEEP;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Tables are snapshotted at launch so later input changes cannot disturb a sweep or its held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spec        <= '0;
            r_impl        <= '0;
            r_vec         <= '0;
            r_mis_cnt     <= '0;
            r_first_mis   <= '0;
            r_first_valid <= 1'b0;
        end else if (w_launch) begin
            r_spec        <= spec_tt;
            r_impl        <= impl_tt;
            r_vec         <= '0;
            r_mis_cnt     <= '0;
            r_first_mis   <= '0;
            r_first_valid <= 1'b0;
        end else if (r_state == S_SWEEP) begin
            if (w_diff) begin
                r_mis_cnt <= r_mis_cnt + CNT_ONE;
                if (!r_first_valid) begin
                    r_first_mis   <= r_vec;
                    r_first_valid <= 1'b1;
                end
            end
            if (!w_stop) begin
                r_vec <= r_vec + VEC_ONE;
            end
        end
    end

    assign busy        = (r_state == S_SWEEP);
    assign done        = (r_state == S_DONE);
    assign equal       = done && (r_mis_cnt == '0);
    assign vec         = r_vec;
    assign mis_cnt     = r_mis_cnt;
    assign first_mis   = r_first_mis;
    assign first_valid = r_first_valid;

endmodule

// File: tb/tb_equiv_sweeper.sv
// Directed self-checking bench for equiv_sweeper at N=4, N=1 and N=8.
// Expected values track the EQUIV_SWEEPER_EARLY_STOP_EN build when that macro is defined.
`timescale 1ns/1ps
module tb_equiv_sweeper;

`ifdef EQUIV_SWEEPER_EARLY_STOP_EN
    localparam bit ES = 1'b1;
`else
    localparam bit ES = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic s4, s1, s8;
    logic [15:0]  sp4, im4;
    logic [1:0]   sp1, im1;
    logic [255:0] sp8, im8;

    logic b4, d4, e4, fv4;
    logic [3:0] v4, f4;
    logic [4:0] m4;
    logic b1, d1, e1, fv1;
    logic [0:0] v1, f1;
    logic [1:0] m1;
    logic b8, d8, e8, fv8;
    logic [7:0] v8, f8;
    logic [8:0] m8;

    int n_cmp = 0;
    int n_err = 0;
    int edges;

    equiv_sweeper #(.N(4)) u4 (
        .clk(clk), .rst(rst), .start(s4), .spec_tt(sp4), .impl_tt(im4),
        .busy(b4), .done(d4), .equal(e4), .vec(v4), .mis_cnt(m4),
        .first_mis(f4), .first_valid(fv4)
    );
    equiv_sweeper #(.N(1)) u1 (
        .clk(clk), .rst(rst), .start(s1), .spec_tt(sp1), .impl_tt(im1),
        .busy(b1), .done(d1), .equal(e1), .vec(v1), .mis_cnt(m1),
        .first_mis(f1), .first_valid(fv1)
    );
    equiv_sweeper #(.N(8)) u8 (
        .clk(clk), .rst(rst), .start(s8), .spec_tt(sp8), .impl_tt(im8),
        .busy(b8), .done(d8), .equal(e8), .vec(v8), .mis_cnt(m8),
        .first_mis(f8), .first_valid(fv8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start4(input logic [15:0] s, input logic [15:0] i);
        @(negedge clk);
        sp4 = s; im4 = i; s4 = 1'b1;
        @(posedge clk); #1;
        s4 = 1'b0;
    endtask

    // Counts edges after the launch edge until done rises; the bound keeps a stuck DUT from hanging.
    task automatic wait_done(input int which, output int n);
        n = 0;
        while (n < 400) begin
            if (which == 4 && d4 === 1'b1) break;
            if (which == 1 && d1 === 1'b1) break;
            if (which == 8 && d8 === 1'b1) break;
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; s4 = 0; s1 = 0; s8 = 0;
        sp4 = '0; im4 = '0; sp1 = '0; im1 = '0; sp8 = '0; im8 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(b4), 0);
        chk("rst_done", 32'(d4), 0);
        chk("rst_equal", 32'(e4), 0);
        chk("rst_vec", 32'(v4), 0);
        chk("rst_mis", 32'(m4), 0);
        chk("rst_first", 32'(f4), 0);
        chk("rst_fv", 32'(fv4), 0);
        chk("rst_n1_done", 32'(d1), 0);
        chk("rst_n8_busy", 32'(b8), 0);
        @(negedge clk);
        rst = 1'b0;

        // Identical tables
        start4(16'h6996, 16'h6996);
        chk("c1_busy0", 32'(b4), 1);
        chk("c1_vec0", 32'(v4), 0);
        wait_done(4, edges);
        chk("c1_edges", 32'(edges), 16);
        chk("c1_equal", 32'(e4), 1);
        chk("c1_mis", 32'(m4), 0);
        chk("c1_fv", 32'(fv4), 0);
        chk("c1_vec", 32'(v4), 15);
        chk("c1_busy", 32'(b4), 0);

        // Two differing bits (5 and 12), restarted from DONE
        start4(16'h00F0, 16'h10D0);
        chk("c2_done_drop", 32'(d4), 0);
        chk("c2_equal_sweep", 32'(e4), 0);
        chk("c2_busy", 32'(b4), 1);
        wait_done(4, edges);
        chk("c2_edges", 32'(edges), ES ? 6 : 16);
        chk("c2_mis", 32'(m4), ES ? 1 : 2);
        chk("c2_first", 32'(f4), 5);
        chk("c2_fv", 32'(fv4), 1);
        chk("c2_equal", 32'(e4), 0);
        chk("c2_vec", 32'(v4), ES ? 5 : 15);
        @(negedge clk);
        sp4 = 16'hFFFF; im4 = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("c2_hold_done", 32'(d4), 1);
        chk("c2_hold_mis", 32'(m4), ES ? 1 : 2);
        chk("c2_hold_first", 32'(f4), 5);

        // Fully inverted implementation
        start4(16'hA5C3, 16'h5A3C);
        wait_done(4, edges);
        chk("c3_edges", 32'(edges), ES ? 1 : 16);
        chk("c3_mis", 32'(m4), ES ? 1 : 16);
        chk("c3_first", 32'(f4), 0);
        chk("c3_fv", 32'(fv4), 1);
        chk("c3_vec", 32'(v4), ES ? 0 : 15);

        // Reset on the 8th sweep edge
        start4(16'hA5C3, 16'h5A3C);
        repeat (7) @(posedge clk);
        #1;
        chk("r_mis_pre", 32'(m4), ES ? 1 : 7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("r_busy", 32'(b4), 0);
        chk("r_done", 32'(d4), 0);
        chk("r_mis", 32'(m4), 0);
        chk("r_fv", 32'(fv4), 0);
        start4(16'hA5C3, 16'h5A3C);
        chk("r_vec0", 32'(v4), 0);
        chk("r_busy_re", 32'(b4), 1);
        @(posedge clk); #1;
        chk("r_vec1", 32'(v4), ES ? 0 : 1);
        wait_done(4, edges);
        chk("r_mis_end", 32'(m4), ES ? 1 : 16);

        // start and table changes mid-sweep are ignored
        start4(16'h6996, 16'h6996);
        repeat (3) @(posedge clk);
        #1;
        s4 = 1'b1; im4 = 16'hFFFF; sp4 = 16'h0000;
        @(posedge clk); #1;
        s4 = 1'b0;
        chk("i_vec", 32'(v4), 4);
        wait_done(4, edges);
        chk("i_edges", 32'(edges + 4), 16);
        chk("i_equal", 32'(e4), 1);
        chk("i_mis", 32'(m4), 0);

        // N=1 equal tables
        @(negedge clk);
        sp1 = 2'b10; im1 = 2'b10; s1 = 1'b1;
        @(posedge clk); #1;
        s1 = 1'b0;
        wait_done(1, edges);
        chk("n1_edges", 32'(edges), 2);
        chk("n1_equal", 32'(e1), 1);
        chk("n1_mis", 32'(m1), 0);

        // N=8 equal tables, then a single mismatch at index 200
        @(negedge clk);
        for (int k = 0; k < 8; k++) sp8[k*32 +: 32] = $urandom();
        im8 = sp8; s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0;
        wait_done(8, edges);
        chk("n8_edges", 32'(edges), 256);
        chk("n8_equal", 32'(e8), 1);
        chk("n8_vec", 32'(v8), 255);
        chk("n8_mis", 32'(m8), 0);
        @(negedge clk);
        im8 = sp8 ^ (256'd1 << 200); s8 = 1'b1;
        @(posedge clk); #1;
        s8 = 1'b0;
        wait_done(8, edges);
        chk("n8m_edges", 32'(edges), ES ? 201 : 256);
        chk("n8m_mis", 32'(m8), 1);
        chk("n8m_first", 32'(f8), 200);
        chk("n8m_equal", 32'(e8), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
